// File: rtl/serializer.sv
// UART-style frame serializer: captures a multi-byte frame and shifts it out
// LSB-first as 8N1 characters, one byte after another with no idle gap.
module serializer #(
    parameter int MSG_BYTES        = 2,
    parameter int KEY_BYTES        = 4,
    parameter int BAUD_RATE        = 9600,
    parameter int INPUT_CLOCK_FREQ = 100_000_000
) (
    input  logic                                      clk_in,
    input  logic                                      rst_n_in,
    input  logic                                      valid_in,
    input  logic [8*(MSG_BYTES + 2*KEY_BYTES)-1:0]    data_in,
    output logic                                      ready_out,
    output logic                                      busy_out,
    output logic                                      done_out,
    output logic                                      tx_wire_out
);

    localparam int BYTES = MSG_BYTES + 2 * KEY_BYTES;
    localparam int CPB   = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CW    = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

    generate
        if (CPB < 2 || BYTES < 1) begin : g_badParams
            $error("serializer: need CPB >= 2 and BYTES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q,   state_d;
    logic [BW-1:0]          byteIdx_q, byteIdx_d;
    logic [2:0]             bitIdx_q,  bitIdx_d;
    logic [CW-1:0]          baudCnt_q, baudCnt_d;
    logic [8*BYTES-1:0]     buffer_q,  buffer_d;
    logic                   tx_q,      tx_d;
    logic                   done_q,    done_d;
    logic                   baudEnd;
    logic [2:0]             bitNext;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            byteIdx_q <= '0;
            bitIdx_q  <= '0;
            baudCnt_q <= '0;
            buffer_q  <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byteIdx_q <= byteIdx_d;
            bitIdx_q  <= bitIdx_d;
            baudCnt_q <= baudCnt_d;
            buffer_q  <= buffer_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    // The line level for the next bit is decided on the edge that ends the
    // current bit, so tx_wire_out changes exactly on bit boundaries.
    always_comb begin
        state_d   = state_q;
        byteIdx_d = byteIdx_q;
        bitIdx_d  = bitIdx_q;
        baudCnt_d = baudCnt_q;
        buffer_d  = buffer_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        baudEnd   = (baudCnt_q == BAUD_LAST);
        bitNext   = bitIdx_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d   = START;
                    buffer_d  = data_in;
                    byteIdx_d = '0;
                    bitIdx_d  = '0;
                    baudCnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (baudEnd) begin
                    state_d   = DATA;
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    tx_d      = buffer_q[{byteIdx_q, 3'd0}];
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baudEnd) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bitIdx_d = bitNext;
                        tx_d     = buffer_q[{byteIdx_q, bitNext}];
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baudEnd) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    if (byteIdx_q == BYTE_LAST) begin
                        state_d   = IDLE;
                        byteIdx_d = '0;
                        done_d    = 1'b1;
                        tx_d      = 1'b1;
                    end else begin
                        state_d   = START;
                        byteIdx_d = byteIdx_q + 1'b1;
                        tx_d      = 1'b0;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign ready_out   = (state_q == IDLE);
    assign busy_out    = ~ready_out;
    assign done_out    = done_q;
    assign tx_wire_out = tx_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: table vectors, back-to-back, reset abort,
// and random frames checked by a waveform model plus a loopback UART receiver.
module tb_serializer;

    localparam int CPB          = 10;
    localparam int BYTES        = 3;
    localparam int FRAME_CYCLES = BYTES * 10 * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] data  = '0;
    logic        ready, busy, done, tx;

    int total = 0;
    int bad   = 0;

    logic [7:0] rxBytes[$];
    bit         rxEnable     = 1'b0;
    int         rxFramingErr = 0;

    typedef struct {
        logic [23:0] frame;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    serializer #(
        .MSG_BYTES(1),
        .KEY_BYTES(1),
        .BAUD_RATE(10_000_000),
        .INPUT_CLOCK_FREQ(100_000_000)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .valid_in(valid),
        .data_in(data),
        .ready_out(ready),
        .busy_out(busy),
        .done_out(done),
        .tx_wire_out(tx)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Ideal 8N1 line level k cycles after the accept edge.
    function automatic logic expectedLevel(input logic [23:0] frame, input int k);
        int n   = k / CPB;
        int pos = n % 10;
        int idx = n / 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return frame[idx*8 + pos - 1];
    endfunction

    task automatic applyStimulus(input logic [23:0] frame, input bit holdValid);
        int waitCycles = 0;
        @(negedge clk);
        while (ready !== 1'b1 && waitCycles < 2000) begin
            @(negedge clk);
            waitCycles++;
        end
        if (ready !== 1'b1) checkOutput("ready wait timeout", {31'd0, ready}, 32'd1);
        data  = frame;
        valid = 1'b1;
        @(posedge clk);
        #1;
        if (!holdValid) valid = 1'b0;
    endtask

    // Called just after the accept edge; ends on the negedge after the done edge.
    task automatic checkFrameBody(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input string tag);
        logic [23:0] expFrame = {e2, e1, e0};
        logic [7:0]  got[3];
        int          lineErr = 0;
        int          statErr = 0;
        for (int k = 0; k < FRAME_CYCLES; k++) begin
            int n   = k / CPB;
            int pos = n % 10;
            @(negedge clk);
            if (tx !== expectedLevel(expFrame, k)) lineErr++;
            if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) statErr++;
            if ((k % CPB) == CPB / 2 && pos >= 1 && pos <= 8) got[n/10][pos-1] = tx;
        end
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("%s byte%0d", tag, i), {24'd0, got[i]}, {24'd0, expFrame[8*i +: 8]});
        checkOutput({tag, " line timing errors"}, lineErr, 0);
        checkOutput({tag, " status errors during frame"}, statErr, 0);
        @(negedge clk);
        checkOutput({tag, " done pulse {done,ready,busy,tx}"}, {28'd0, done, ready, busy, tx}, 32'b1101);
    endtask

    // Independent loopback receiver: samples mid-bit after each falling start edge.
    initial begin
        logic [7:0] rxByte;
        forever begin
            @(negedge clk);
            if (rxEnable && rst_n && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rxByte[b] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) rxFramingErr++;
                rxBytes.push_back(rxByte);
            end
        end
    end

    initial begin
        #600_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          idleErr;
        int          rstErr;
        logic [23:0] sent[$];
        logic [23:0] f;
        logic [23:0] rxFrame;

        vecs[0] = '{24'hC35AA5, 8'hA5, 8'h5A, 8'hC3};
        vecs[1] = '{24'h000000, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{24'h8001FE, 8'hFE, 8'h01, 8'h80};

        #23;
        checkOutput("reset {done,ready,busy,tx}", {28'd0, done, ready, busy, tx}, 32'b0101);
        @(negedge clk);
        rst_n = 1'b1;

        idleErr = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idleErr++;
        end
        checkOutput("idle 100 cycles", idleErr, 0);

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].frame, 1'b0);
            checkFrameBody(vecs[v].b0, vecs[v].b1, vecs[v].b2, $sformatf("vec%0d", v));
        end

        // Back-to-back: new data offered during the frame must wait for done.
        applyStimulus(24'hC35AA5, 1'b1);
        data = 24'h112233;
        checkFrameBody(8'hA5, 8'h5A, 8'hC3, "b2b first");
        @(posedge clk);
        #1;
        valid = 1'b0;
        checkFrameBody(8'h33, 8'h22, 8'h11, "b2b second");

        // Reset 150 cycles into an all-zero frame, with valid held during reset.
        applyStimulus(24'h000000, 1'b0);
        repeat (150) @(negedge clk);
        checkOutput("pre-reset line low", {31'd0, tx}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset {done,ready,busy,tx}", {28'd0, done, ready, busy, tx}, 32'b0101);
        valid = 1'b1;
        data  = 24'h0000FF;
        rstErr = 0;
        for (int c = 0; c < 350; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) rstErr++;
        end
        checkOutput("held reset state", rstErr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        checkFrameBody(8'hFF, 8'h00, 8'h00, "post-reset");

        rxBytes.delete();
        rxFramingErr = 0;
        rxEnable = 1'b1;
        for (int r = 0; r < 20; r++) begin
            f = 24'($urandom);
            sent.push_back(f);
            applyStimulus(f, 1'b0);
            checkFrameBody(f[7:0], f[15:8], f[23:16], $sformatf("rand%0d", r));
        end
        repeat (20) @(negedge clk);
        rxEnable = 1'b0;
        checkOutput("loopback byte count", rxBytes.size(), 60);
        checkOutput("loopback framing errors", rxFramingErr, 0);
        for (int r = 0; r < 20; r++) begin
            if (rxBytes.size() >= 3) begin
                rxFrame[7:0]   = rxBytes.pop_front();
                rxFrame[15:8]  = rxBytes.pop_front();
                rxFrame[23:16] = rxBytes.pop_front();
            end else begin
                rxFrame = 24'hxxxxxx;
            end
            checkOutput($sformatf("loopback frame%0d", r), {8'd0, rxFrame}, {8'd0, sent[r]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter MSG_BYTES, default 2, message bytes per frame.
REQ-002 Parameter KEY_BYTES, default 4, bytes per key; frame carries two keys.
REQ-003 Parameter BAUD_RATE, default 9600, UART bit rate in bits/s.
REQ-004 Parameter INPUT_CLOCK_FREQ, default 100_000_000, clk_in frequency in Hz.
REQ-005 Derived: BYTES = MSG_BYTES + 2*KEY_BYTES; CPB = INPUT_CLOCK_FREQ / BAUD_RATE (integer division, truncated).
REQ-006 clk_in  input  1  single clock; all logic on rising edge.
REQ-007 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-008 valid_in  input  1  frame offer; accepted only when ready_out=1.
REQ-009 data_in  input  8*BYTES  frame; byte i = data_in[8*i+7:8*i].
REQ-010 ready_out  output  1  high when idle and able to accept a frame.
REQ-011 busy_out  output  1  high while a frame is being shifted out.
REQ-012 done_out  output  1  one-cycle pulse after the final stop bit completes.
REQ-013 tx_wire_out  output  1  UART serial line, idle high, registered.

Function
REQ-014 States SHALL be IDLE, START, DATA, STOP.
REQ-015 Accept = valid_in & ready_out at a rising edge; on that edge the block captures data_in into an internal buffer, enters START, drives tx_wire_out=0, ready_out=0, busy_out=1.
REQ-016 valid_in while ready_out=0 SHALL be ignored; captured buffer is not altered by data_in after accept.
REQ-017 Byte order: byte 0 first, byte BYTES-1 last; bit order within a byte: bit 0 first (8N1).
REQ-018 Each bit (start, 8 data, stop) SHALL hold tx_wire_out for exactly CPB clk_in cycles, timed by a baud counter counting 0..CPB-1.
REQ-019 START -> DATA after CPB cycles; DATA -> STOP after 8 bit periods; STOP -> START of next byte with no idle gap if bytes remain.
REQ-020 STOP of byte BYTES-1 -> IDLE after CPB cycles; on that edge done_out=1 for one cycle, ready_out=1, busy_out=0, tx_wire_out=1.
REQ-021 Latency: accept edge to done_out edge = BYTES*10*CPB cycles exactly.
REQ-022 An accept in the cycle done_out=1 SHALL start the next start bit immediately (back-to-back frames, no extra idle bit).
REQ-023 Byte index width $clog2(BYTES) (min 1); bit index 3 bits; baud counter width $clog2(CPB) (min 1); index wraps to 0 on frame end.
REQ-024 CPB < 2 or BYTES < 1 SHALL be an elaboration error.
REQ-025 ready_out = 1 exactly when state is IDLE; busy_out = not ready_out.

Reset
REQ-026 rst_n_in=0 SHALL immediately (asynchronously) force state IDLE, tx_wire_out=1, ready_out=1, busy_out=0, done_out=0, all counters and buffer 0.
REQ-027 Reset mid-frame SHALL abort transmission without emitting done_out; first accept after release starts a fresh frame at byte 0.
REQ-028 valid_in asserted during reset SHALL not be accepted; first accept possible on the first rising edge with rst_n_in=1.

Verification (CPB=10 via BAUD_RATE=10_000_000, INPUT_CLOCK_FREQ=100_000_000, MSG_BYTES=1, KEY_BYTES=1, BYTES=3)
REQ-029 Idle after reset: no valid_in for 100 cycles -> tx_wire_out=1, ready_out=1, done_out never pulses.
REQ-030 Single frame data_in=24'hC3_5A_A5 -> wire bytes A5, 5A, C3 each framed 0,b0..b7,1 with 10-cycle bits; done_out pulses exactly 300 cycles after accept.
REQ-031 valid_in held high with new data_in=24'h112233 during a frame -> ignored; second frame starts on the done_out cycle, start bit directly follows prior stop bit.
REQ-032 rst_n_in low 150 cycles into a frame -> tx_wire_out=1 same cycle, no done_out; subsequent frame 24'h0000FF sent correctly.
REQ-033 Loopback tx_wire_out into deserializer (same parameters) for 20 random frames -> deserializer data_out equals each data_in in order.
